picorv32_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter on the PicoRV32 native memory bus.
- Sits directly upstream of the tightly-coupled memory (TCM).
- Master 0 is the PicoRV32 core; master 1 is a loader/DMA engine that preloads or inspects TCM.
- Round-robin arbitration with a registered grant; one transaction at a time; read data broadcast to both masters.

---
 rtl/picorv32_bus_arbiter_pkg.sv | 29 ++
 rtl/picorv32_bus_arbiter_if.sv | 18 +
 rtl/picorv32_bus_arbiter.sv | 103 ++++++++++
 tb/tb_picorv32_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_bus_arbiter_pkg.sv
// Shared types for the PicoRV32 native-bus arbiter: FSM states, request bundle, grant decode.
package picorv32_bus_pkg;

  localparam int BUS_ADDR_WIDTH = 8;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Everything a master presents that must be steered to the slave as one unit
  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_DATA_WIDTH-1:0] wdata;
    logic [BUS_STRB_WIDTH-1:0] wstrb;
  } bus_req_t;

  function automatic logic [1:0] grant_of(input arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == OWN0) g = 2'b01;
    else if (st == OWN1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/picorv32_bus_arbiter_if.sv
// PicoRV32 native memory bus; master drives the request, slave answers with ready/rdata.
interface picorv32_bus_arbiter_if
  import picorv32_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH
) ();

  logic                      valid;
  logic                      ready;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [BUS_DATA_WIDTH-1:0] wdata;
  logic [BUS_STRB_WIDTH-1:0] wstrb;
  logic [BUS_DATA_WIDTH-1:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/picorv32_bus_arbiter.sv
// Two-master round-robin arbiter in front of the TCM; one transaction at a time, rdata broadcast.
module picorv32_bus_arbiter
  import picorv32_bus_pkg::*;
#(
  parameter int ADDR_WIDTH        = BUS_ADDR_WIDTH,
  parameter bit M0_PRIORITY_FIRST = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  picorv32_bus_arbiter_if.slave     m0,
  picorv32_bus_arbiter_if.slave     m1,
  picorv32_bus_arbiter_if.master    s,
  output logic [BUS_DATA_WIDTH-1:0] m_rdata,
  output logic [ADDR_WIDTH-1:0]     s_la_addr,
  output logic [1:0]                grant
);

  arb_state_t state_q, state_d;
  // 0: master 0 finished last, 1: master 1 finished last; ties go to the other one
  logic       last_owner_q, last_owner_d;

  bus_req_t   m0_req, m1_req, sel_req;
  logic       s_valid_c;
  logic       m0_ready_c, m1_ready_c;

  // The request bundle carries package-width addresses; keep BUS_ADDR_WIDTH >= ADDR_WIDTH
  assign m0_req.addr  = BUS_ADDR_WIDTH'(m0.addr);
  assign m0_req.wdata = m0.wdata;
  assign m0_req.wstrb = m0.wstrb;
  assign m1_req.addr  = BUS_ADDR_WIDTH'(m1.addr);
  assign m1_req.wdata = m1.wdata;
  assign m1_req.wstrb = m1.wstrb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= M0_PRIORITY_FIRST;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    sel_req      = '0;
    s_valid_c    = 1'b0;
    m0_ready_c   = 1'b0;
    m1_ready_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0.valid && m1.valid) state_d = last_owner_q ? OWN0 : OWN1;
        else if (m0.valid)        state_d = OWN0;
        else if (m1.valid)        state_d = OWN1;
      end

      OWN0: begin
        sel_req    = m0_req;
        s_valid_c  = m0.valid;
        m0_ready_c = s.ready & m0.valid;
        // Dropping valid without ready is a protocol error; just release the bus
        if (!m0.valid) begin
          state_d = IDLE;
        end else if (s.ready) begin
          last_owner_d = 1'b0;
          // PicoRV32 keeps valid high in the ready cycle, so never re-grant the same master here
          state_d      = m1.valid ? OWN1 : IDLE;
        end
      end

      OWN1: begin
        sel_req    = m1_req;
        s_valid_c  = m1.valid;
        m1_ready_c = s.ready & m1.valid;
        if (!m1.valid) begin
          state_d = IDLE;
        end else if (s.ready) begin
          last_owner_d = 1'b1;
          state_d      = m0.valid ? OWN0 : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign s.valid   = s_valid_c;
  assign s.addr    = ADDR_WIDTH'(sel_req.addr);
  assign s.wdata   = sel_req.wdata;
  assign s.wstrb   = sel_req.wstrb;
  assign s_la_addr = ADDR_WIDTH'(sel_req.addr);

  assign m0.ready  = m0_ready_c;
  assign m1.ready  = m1_ready_c;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;
  assign m_rdata   = s.rdata;

  assign grant     = grant_of(state_q);

endmodule

// File: tb/tb_picorv32_bus_arbiter.sv
// Directed bench: arbiter driving a small behavioural TCM (write ready 1st cycle, read ready 2nd).
module tb_picorv32_bus_arbiter;

  logic        clock;
  logic        reset_n;
  logic [31:0] m_rdata;
  logic [7:0]  s_la_addr;
  logic [1:0]  grant;

  picorv32_bus_arbiter_if #(.ADDR_WIDTH(8)) m0_if ();
  picorv32_bus_arbiter_if #(.ADDR_WIDTH(8)) m1_if ();
  picorv32_bus_arbiter_if #(.ADDR_WIDTH(8)) s_if ();

  picorv32_bus_arbiter #(.ADDR_WIDTH(8), .M0_PRIORITY_FIRST(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .m_rdata   (m_rdata),
    .s_la_addr (s_la_addr),
    .grant     (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural TCM, reloaded while reset is low
  logic [31:0] mem [64];
  logic        rd_ready_q;
  logic [31:0] rdata_q;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] hi;
    hi = 8'(i);
    return (i == 4) ? 32'hDEADBEEF : {hi, 24'h223344};
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      rd_ready_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (s_if.valid && (s_if.wstrb != 4'b0000)) begin
        for (int b = 0; b < 4; b++)
          if (s_if.wstrb[b]) mem[s_if.addr[7:2]][8*b +: 8] <= s_if.wdata[8*b +: 8];
      end
      rd_ready_q <= s_if.valid && (s_if.wstrb == 4'b0000) && !rd_ready_q;
      rdata_q    <= mem[s_if.addr[7:2]];
    end
  end

  assign s_if.ready = (s_if.valid && (s_if.wstrb != 4'b0000)) || rd_ready_q;
  assign s_if.rdata = rdata_q;

  // Structural invariants sampled every cycle
  int viol = 0;
  always @(negedge clock) begin
    if (reset_n) begin
      if (m0_if.ready && m1_if.ready)               viol <= viol + 1;
      else if (s_if.valid && grant == 2'b00)        viol <= viol + 1;
      else if (grant == 2'b11)                      viol <= viol + 1;
      else if (m0_if.ready && grant != 2'b01)       viol <= viol + 1;
      else if (m1_if.ready && grant != 2'b10)       viol <= viol + 1;
      else if (s_la_addr != s_if.addr)              viol <= viol + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_m(input int m, input logic v, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (m == 0) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_m(0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_m(1, 1'b0, 8'h00, 32'h0, 4'h0);
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  // Issue one request from IDLE and wait (bounded) for its ready; lat counts the request cycle
  task automatic xact(input string tag, input int m, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output int lat);
    logic got;
    got = 1'b0;
    rd  = '0;
    lat = 1;
    set_m(m, 1'b1, a, wd, ws);
    for (int i = 0; i < 16 && !got; i++) begin
      cyc();
      lat++;
      @(negedge clock);
      if ((m == 0) ? m0_if.ready : m1_if.ready) begin
        got = 1'b1;
        rd  = m_rdata;
      end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    cyc();
    set_m(m, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  logic [31:0] rd;
  int          lat;
  int          n0, n1, nown, data_err;
  logic [7:0]  own_bits;
  logic        r0, r1;

  initial begin
    do_reset();
    @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_svalid", 32'(s_if.valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_if.ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_if.ready), 32'd0);

    // Single read by m0 of word 4
    cyc();
    set_m(0, 1'b1, 8'h10, 32'h0, 4'h0);
    @(negedge clock);
    chk("t1_c0_svalid", 32'(s_if.valid), 32'd0);
    cyc();
    @(negedge clock);
    chk("t1_c1_svalid", 32'(s_if.valid), 32'd1);
    chk("t1_c1_grant", 32'(grant), 32'd1);
    chk("t1_c1_saddr", 32'(s_if.addr), 32'h10);
    chk("t1_c1_m0_ready", 32'(m0_if.ready), 32'd0);
    cyc();
    @(negedge clock);
    chk("t1_c2_m0_ready", 32'(m0_if.ready), 32'd1);
    chk("t1_c2_rdata", m_rdata, 32'hDEADBEEF);
    chk("t1_c2_m0_if_rdata", m0_if.rdata, 32'hDEADBEEF);
    chk("t1_c2_m1_ready", 32'(m1_if.ready), 32'd0);
    cyc();
    set_m(0, 1'b0, 8'h00, 32'h0, 4'h0);

    // Partial write by m1 then readback by m0
    xact("t2_wr", 1, 8'h20, 32'hA5A5A5A5, 4'b0011, rd, lat);
    chk("t2_wr_lat", 32'(lat), 32'd2);
    xact("t2_rd", 0, 8'h20, 32'h0, 4'b0000, rd, lat);
    chk("t2_rd_lat", 32'(lat), 32'd3);
    chk("t2_rd_data", rd, 32'h0822A5A5);

    // Simultaneous first request after reset: m0 wins, m1 follows with no idle cycle
    do_reset();
    set_m(0, 1'b1, 8'h10, 32'h0, 4'h0);
    set_m(1, 1'b1, 8'h08, 32'h0, 4'h0);
    cyc();
    @(negedge clock);
    chk("t3_c1_grant", 32'(grant), 32'd1);
    chk("t3_c1_saddr", 32'(s_if.addr), 32'h10);
    cyc();
    @(negedge clock);
    chk("t3_c2_m0_ready", 32'(m0_if.ready), 32'd1);
    chk("t3_c2_m1_ready", 32'(m1_if.ready), 32'd0);
    cyc();
    set_m(0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clock);
    chk("t3_c3_grant", 32'(grant), 32'd2);
    chk("t3_c3_svalid", 32'(s_if.valid), 32'd1);
    chk("t3_c3_saddr", 32'(s_if.addr), 32'h08);
    cyc();
    @(negedge clock);
    chk("t3_c4_m1_ready", 32'(m1_if.ready), 32'd1);
    chk("t3_c4_m1_if_rdata", m1_if.rdata, 32'h02223344);
    cyc();
    set_m(1, 1'b0, 8'h00, 32'h0, 4'h0);

    // Continuous contention: 4 reads each, both re-request right after their ready
    n0 = 0; n1 = 0; nown = 0; data_err = 0; own_bits = '0;
    set_m(0, 1'b1, 8'h00, 32'h0, 4'h0);
    set_m(1, 1'b1, 8'h40, 32'h0, 4'h0);
    for (int c = 0; c < 64 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clock);
      r0 = m0_if.ready;
      r1 = m1_if.ready;
      if (r0) begin
        if (m_rdata !== init_word(n0)) data_err++;
        if (nown < 8) own_bits[nown] = 1'b0;
        nown++;
      end
      if (r1) begin
        if (m_rdata !== init_word(16 + n1)) data_err++;
        if (nown < 8) own_bits[nown] = 1'b1;
        nown++;
      end
      cyc();
      if (r0) begin n0++; set_m(0, n0 < 4, 8'(n0 * 4), 32'h0, 4'h0); end
      if (r1) begin n1++; set_m(1, n1 < 4, 8'(8'h40 + n1 * 4), 32'h0, 4'h0); end
    end
    set_m(0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_m(1, 1'b0, 8'h00, 32'h0, 4'h0);
    chk("t4_done0", 32'(n0), 32'd4);
    chk("t4_done1", 32'(n1), 32'd4);
    chk("t4_total", 32'(nown), 32'd8);
    chk("t4_owner_seq", 32'(own_bits), 32'hAA);
    chk("t4_data_err", 32'(data_err), 32'd0);

    // Reset asserted in the middle of an m1 read
    set_m(1, 1'b1, 8'h08, 32'h0, 4'h0);
    cyc();
    @(negedge clock);
    chk("t5_own_grant", 32'(grant), 32'd2);
    chk("t5_own_svalid", 32'(s_if.valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_svalid", 32'(s_if.valid), 32'd0);
    chk("t5_rst_m1_ready", 32'(m1_if.ready), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    set_m(1, 1'b0, 8'h00, 32'h0, 4'h0);
    cyc();
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_post_grant", 32'(grant), 32'd0);
    chk("t5_post_svalid", 32'(s_if.valid), 32'd0);
    cyc();

    // m0 write to word 1 while m1 holds a read of word 2
    set_m(1, 1'b1, 8'h08, 32'h0, 4'h0);
    cyc();
    set_m(0, 1'b1, 8'h04, 32'hCAFEF00D, 4'hF);
    @(negedge clock);
    chk("t6_c1_grant", 32'(grant), 32'd2);
    chk("t6_c1_swstrb", 32'(s_if.wstrb), 32'd0);
    chk("t6_c1_m0_ready", 32'(m0_if.ready), 32'd0);
    cyc();
    @(negedge clock);
    chk("t6_c2_m1_ready", 32'(m1_if.ready), 32'd1);
    chk("t6_c2_m0_ready", 32'(m0_if.ready), 32'd0);
    chk("t6_c2_saddr", 32'(s_if.addr), 32'h08);
    chk("t6_c2_rdata", m_rdata, 32'h02223344);
    chk("t6_c2_word1_untouched", mem[1], 32'h01223344);
    cyc();
    set_m(1, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clock);
    chk("t6_c3_grant", 32'(grant), 32'd1);
    chk("t6_c3_m0_ready", 32'(m0_if.ready), 32'd1);
    chk("t6_c3_swdata", s_if.wdata, 32'hCAFEF00D);
    cyc();
    set_m(0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clock);
    chk("t6_word1_written", mem[1], 32'hCAFEF00D);
    chk("t6_end_grant", 32'(grant), 32'd0);

    chk("invariant_viol", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
